// File: rtl/pc_fetch.sv
// Instruction fetch stage: PC register, registered IR/IRPC, redirect and
// RUN/HALT/FAULT control against a combinational instruction memory.
module pc_fetch (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Stall,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] Immediate,
    input  logic [25:0] JumpAddr,
    input  logic [31:0] RegAddr,
    input  logic [31:0] IDataIn,
    output logic [31:0] PC,
    output logic        InsMemRW,
    output logic [31:0] IR,
    output logic [31:0] IRPC,
    output logic        IRValid,
    output logic [1:0]  State
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_HALT  = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    localparam logic [1:0]  SRC_SEQ    = 2'b00;
    localparam logic [1:0]  SRC_BRANCH = 2'b01;
    localparam logic [1:0]  SRC_JUMP   = 2'b10;
    localparam logic [31:0] PC_MAX     = 32'd508;
    localparam logic [5:0]  OP_HALT    = 6'b111111;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] irpc_q, irpc_d;
    logic        irvalid_q, irvalid_d;

    logic [31:0] irpc_plus4;
    logic [31:0] target;
    logic        halt_hit;
    logic        fault_hit;
    logic        redirect_hit;

    assign irpc_plus4 = irpc_q + 32'd4;

    always_comb begin
        case (PCSrc)
            SRC_BRANCH: target = irpc_plus4 + {Immediate[29:0], 2'b00};
            SRC_JUMP:   target = {irpc_plus4[31:28], JumpAddr, 2'b00};
            default:    target = RegAddr;
        endcase
    end

    assign halt_hit     = irvalid_q && (ir_q[31:26] == OP_HALT);
    assign fault_hit    = (pc_q[1:0] != 2'b00) || (pc_q > PC_MAX);
    assign redirect_hit = irvalid_q && (PCSrc != SRC_SEQ);

    // Priority within RUN: stall, halt, fault, redirect, sequential fetch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        irpc_d    = irpc_q;
        irvalid_d = irvalid_q;
        if (state_q == ST_RUN && !Stall) begin
            if (halt_hit) begin
                state_d   = ST_HALT;
                irvalid_d = 1'b0;
            end else if (fault_hit) begin
                state_d   = ST_FAULT;
                irvalid_d = 1'b0;
            end else if (redirect_hit) begin
                pc_d      = target;
                ir_d      = 32'd0;
                irvalid_d = 1'b0;
            end else begin
                pc_d      = pc_q + 32'd4;
                ir_d      = IDataIn;
                irpc_d    = pc_q;
                irvalid_d = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values computed above, independent of block order.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_RUN;
            pc_q      <= 32'd0;
            ir_q      <= 32'd0;
            irpc_q    <= 32'd0;
            irvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            irpc_q    <= irpc_d;
            irvalid_q <= irvalid_d;
        end
    end

    assign PC       = pc_q;
    assign IR       = ir_q;
    assign IRPC     = irpc_q;
    assign IRValid  = irvalid_q;
    assign State    = state_q;
    assign InsMemRW = (state_q == ST_RUN);

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: asynchronous reset, active-low (0 = reset).
REQ-003 SHALL have port Stall, input, 1 bit: 1 = downstream not ready; hold all state.
REQ-004 SHALL have port PCSrc, input, 2 bits: redirect request for the instruction in IR. 00 = sequential, 01 = branch, 10 = jump, 11 = register jump.
REQ-005 SHALL have port Immediate, input, 32 bits: sign-extended branch offset, in words.
REQ-006 SHALL have port JumpAddr, input, 26 bits: jump target field.
REQ-007 SHALL have port RegAddr, input, 32 bits: register-jump target.
REQ-008 SHALL have port IDataIn, input, 32 bits: instruction from the combinational instruction memory at address PC.
REQ-009 SHALL have port PC, output, 32 bits: fetch address; drives the instruction memory address.
REQ-010 SHALL have port InsMemRW, output, 1 bit: memory read enable; 1 = read.
REQ-011 SHALL have port IR, output, 32 bits: registered instruction.
REQ-012 SHALL have port IRPC, output, 32 bits: address of the instruction in IR.
REQ-013 SHALL have port IRValid, output, 1 bit: IR holds a live instruction.
REQ-014 SHALL have port State, output, 2 bits: 00 RUN, 01 HALT, 10 FAULT.

Function
REQ-015 SHALL implement FSM states RUN, HALT and FAULT; HALT and FAULT are sticky until Reset.
REQ-016 SHALL drive InsMemRW = 1 in RUN and 0 in HALT/FAULT, combinationally from state.
REQ-017 SHALL compute targets from IRPC with 32-bit wrap-around arithmetic:
- branch = IRPC+4+(Immediate<<2)
- jump = {(IRPC+4)[31:28], JumpAddr, 2'b00}
- register jump = RegAddr
REQ-018 SHALL ignore PCSrc while IRValid = 0.
REQ-019 SHALL evaluate per edge in RUN with the following priority: Stall, halt, fault, redirect, sequential.
REQ-020 SHALL hold PC, IR, IRPC, IRValid and State unchanged on an edge with Stall = 1.
REQ-021 SHALL enter HALT when IRValid = 1 and IR[31:26] = 6'b111111; at that edge IRValid <= 0 and PC, IR, IRPC hold.
REQ-022 SHALL enter FAULT when not halting and PC[1:0] != 0 or PC > 32'd508; at that edge IRValid <= 0, PC holds, and IR is not captured.
REQ-023 SHALL perform a redirect when IRValid = 1 and PCSrc != 00: PC <= target, IR <= 0, IRValid <= 0 (one-cycle flush bubble); IDataIn is discarded.
REQ-024 SHALL otherwise fetch sequentially: IR <= IDataIn, IRPC <= PC, IRValid <= 1, PC <= PC+4.
REQ-025 SHALL resolve halt together with a redirect in favour of halt.
REQ-026 SHALL check an out-of-range redirect target on the following RUN edge, when it is the presented PC.
REQ-027 SHALL have a fetch latency of one edge from PC presented to IR valid; redirect penalty is exactly one bubble cycle.

Reset
REQ-028 SHALL, while Reset = 0, immediately force PC = 0, IR = 0, IRPC = 0, IRValid = 0, State = RUN, regardless of CLK.
REQ-029 SHALL, on reset asserted mid-operation (including in HALT/FAULT), discard all state; the first edge after release fetches address 0.

Verification
REQ-030 SHALL cover sequential fetch: release reset, memory words 0x00000001, 0x00000002, 0x00000003 at 0, 4, 8, Stall = 0, PCSrc = 00 -> after 3 edges IR = 0x00000003, IRPC = 8, PC = 12, IRValid = 1.
REQ-031 SHALL cover branch flush: IR valid at IRPC = 4, PCSrc = 01, Immediate = 0xFFFFFFFF -> next edge PC = 4, IRValid = 0, IR = 0; following edge IR = mem[4], IRValid = 1.
REQ-032 SHALL cover jump and register jump:
- IRPC = 0x10, PCSrc = 10, JumpAddr = 0x40 -> PC = 0x100.
- PCSrc = 11, RegAddr = 0x20 -> PC = 0x20.
REQ-033 SHALL cover stall: Stall = 1 for 3 edges with PC = 8 -> PC, IR, IRValid unchanged; release -> fetch resumes at 8.
REQ-034 SHALL cover halt and fault:
- IR = 0xFC000000 valid -> State = 01, InsMemRW = 0, PC frozen for 10 edges.
- Separately, RegAddr = 0x202 jump -> PC = 0x202, then next edge State = 10, IRValid = 0.
REQ-035 SHALL cover async reset: assert Reset = 0 mid-cycle in FAULT -> outputs zero without a clock edge, State = 00; release -> IR = mem[0] after one edge.
